fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction fetch queue between the fetch stage (PC/IMEM/branch predictor) and decode, replacing the fixed single-entry stage-0/stage-1 pipeline registers. It buffers up to DEPTH fetched instructions with their prediction metadata, decouples fetch from decode stalls with a valid/ready handshake, and discards all contents on a mispredict flush.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- XLEN, 32: PC and instruction width.
- AFULL_LVL, DEPTH-1: `count` threshold at which `almost_full` asserts; 1..DEPTH.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  mispredict/pipeline reset; empties the queue.
- enq_valid  in  1  fetch presents an entry.
- enq_ready  out  1  queue accepts an entry this cycle.
- enq_pc  in  XLEN  PC of fetched instruction.
- enq_inst  in  XLEN  instruction word.
- enq_pred_taken  in  1  predictor direction.
- enq_pred_target  in  XLEN  predicted next PC.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  decode consumes head this cycle.
- deq_pc, deq_inst, deq_pred_target  out  XLEN  head entry fields.
- deq_pred_taken  out  1  head entry field.
- count  out  $clog2(DEPTH+1)  occupied entries.
- almost_full  out  1  count ≥ AFULL_LVL.

## Operation
- Circular buffer, write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits plus one wrap bit; full when indices equal and wrap bits differ, empty when both equal.
- Enqueue fires when enq_valid && enq_ready; entry written at `wp`, `wp` increments (wraps DEPTH-1 → 0, toggles wrap bit).
- Dequeue fires when deq_valid && deq_ready; `rp` increments likewise.
- enq_ready = !full && !flush. No same-cycle enqueue into a full queue even if a dequeue fires.
- deq_valid = !empty && !flush (plus bypass case, see Configuration).
- Simultaneous enqueue and dequeue on non-full, non-empty queue: count unchanged, both pointers advance.
- count = wp − rp (modular, wrap-bit aware); registered, updated +1/−1/0.
- flush: next cycle wp = rp = 0, count = 0; enqueue and dequeue in the flush cycle are ignored (neither handshake fires).
- Reset (rst=0): same as flush; also clears all entry storage to 0. Reset takes priority over flush and handshakes.
- deq_* data fields are don't-care when deq_valid=0 but must hold stable while deq_valid=1 and deq_ready=0.

## Timing
- Reset values: enq_ready=1 (after reset released; 0 while rst=0), deq_valid=0, count=0, almost_full=0, deq_* data=0.
- Latency enqueue→deq_valid: 1 cycle (entry written at edge N visible from cycle N+1).
- Throughput: one enqueue and one dequeue per cycle sustained.
- flush asserted in cycle N: deq_valid=0 and enq_ready=0 in cycle N; queue empty, enq_ready=1 in N+1.
- Full→one dequeue at edge N: enq_ready=1 in N+1.
- almost_full, count are registered-state decodes; no combinational path from enq_valid/deq_ready.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when queue empty and not flushing, enq_* passes combinationally to deq_* with deq_valid=enq_valid; if deq_ready also high, the entry is consumed without being written (count stays 0). Zero-cycle latency on an empty queue.
- Undefined: no bypass; enq→deq path always registered, 1-cycle minimum latency; no combinational path from enq_* to deq_*.

## Structure
- Shared package `fetch_pkg`: `fq_entry_t` packed struct {pc, inst, pred_taken, pred_target}, XLEN default constant, pointer-width helper.
- One sub-module: `fetch_queue_mem` — DEPTH×fq_entry_t register array, one write port, one async read port, synchronous clear on reset.

## Test plan
- Reset then fill: DEPTH=4, enqueue PCs 0x00,0x04,0x08,0x0C with deq_ready=0 → count=4, enq_ready=0, almost_full=1 from count=3; dequeue returns 0x00..0x0C in order.
- Wrap: enqueue/dequeue 10 entries alternating with 2-deep occupancy → order preserved across pointer wrap, count never exceeds 2.
- Simultaneous: count=2, enq and deq same cycle for 5 cycles → count stays 2, output sequence matches input.
- Flush mid-stream: count=3, flush with enq_valid=1 and deq_ready=1 → no handshake that cycle, next cycle count=0, deq_valid=0, enq_ready=1.
- Reset mid-operation: count=3, rst=0 one cycle → count=0, deq_valid=0, deq_pc=0.
- Bypass (FETCH_QUEUE_BYPASS_EN): empty queue, enq_pc=0x40 with deq_ready=1 → deq_valid=1, deq_pc=0x40 same cycle, count stays 0; without macro deq_pc=0x40 appears one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: queue entry layout, default word width, pointer-width helper.
// Used by fetch_queue and fetch_queue_mem; no state of its own.
package fetch_pkg;

   localparam int FQ_XLEN = 32;

   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [FQ_XLEN-1:0] inst;
      logic               pred_taken;
      logic [FQ_XLEN-1:0] pred_target;
   } fq_entry_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one write port, asynchronous read port, clear on reset.
// The write takes effect at the clock edge and the read is combinational; there is no backpressure.
module fetch_queue_mem
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = ptr_w(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  fq_entry_t       i_wdat,
   input  logic [AW-1:0]   i_raddr,
   output fq_entry_t       o_rdat
);

   fq_entry_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdat;
      end
   end

   assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: 1-cycle enq->deq latency (0 on an empty queue with FETCH_QUEUE_BYPASS_EN).
// Backpressure: enq_ready drops when full or flushing; flush empties the queue in one cycle.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int XLEN      = FQ_XLEN,
   parameter int AFULL_LVL = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [XLEN-1:0]            enq_pc,
   input  logic [XLEN-1:0]            enq_inst,
   input  logic                       enq_pred_taken,
   input  logic [XLEN-1:0]            enq_pred_target,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [XLEN-1:0]            deq_pc,
   output logic [XLEN-1:0]            deq_inst,
   output logic                       deq_pred_taken,
   output logic [XLEN-1:0]            deq_pred_target,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

   logic [PW:0]   r_wp;
   logic [PW:0]   r_rp;
   logic [CW-1:0] r_count;

   logic      w_full;
   logic      w_empty;
   logic      w_active;
   logic      w_byp;
   logic      w_enq_fire;
   logic      w_deq_fire;
   logic      w_push;
   logic      w_pop;
   fq_entry_t w_enq_ent;
   fq_entry_t w_mem_ent;
   fq_entry_t w_head;

   assign w_full   = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
   assign w_empty  = (r_wp == r_rp);
   assign w_active = rst && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign w_byp = w_empty && w_active;
`else
   assign w_byp = 1'b0;
`endif

   assign w_enq_ent.pc          = enq_pc;
   assign w_enq_ent.inst        = enq_inst;
   assign w_enq_ent.pred_taken  = enq_pred_taken;
   assign w_enq_ent.pred_target = enq_pred_target;

   assign enq_ready  = !w_full && w_active;
   assign deq_valid  = w_byp ? enq_valid : (!w_empty && w_active);
   assign w_head     = w_byp ? w_enq_ent : w_mem_ent;
   assign w_enq_fire = enq_valid && enq_ready;
   assign w_deq_fire = deq_valid && deq_ready;

   // A bypassed entry consumed in the same cycle never touches storage or pointers.
   assign w_push = w_enq_fire && !(w_byp && deq_ready);
   assign w_pop  = w_deq_fire && !w_byp;

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_push),
      .i_waddr (r_wp[PW-1:0]),
      .i_wdat  (w_enq_ent),
      .i_raddr (r_rp[PW-1:0]),
      .o_rdat  (w_mem_ent)
   );

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign deq_pc          = w_head.pc;
   assign deq_inst        = w_head.inst;
   assign deq_pred_taken  = w_head.pred_taken;
   assign deq_pred_target = w_head.pred_target;
   assign count           = r_count;
   assign almost_full     = (r_count >= AFULL_CNT);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): reset, fill/drain, wrap, simultaneous traffic, flush, reset, latency.
// Covers FETCH_QUEUE_BYPASS_EN when that macro is defined for the build.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        enq_valid;
   logic        enq_ready;
   logic [31:0] enq_pc;
   logic [31:0] enq_inst;
   logic        enq_pred_taken;
   logic [31:0] enq_pred_target;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_pc;
   logic [31:0] deq_inst;
   logic        deq_pred_taken;
   logic [31:0] deq_pred_target;
   logic [2:0]  count;
   logic        almost_full;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .enq_valid       (enq_valid),
      .enq_ready       (enq_ready),
      .enq_pc          (enq_pc),
      .enq_inst        (enq_inst),
      .enq_pred_taken  (enq_pred_taken),
      .enq_pred_target (enq_pred_target),
      .deq_valid       (deq_valid),
      .deq_ready       (deq_ready),
      .deq_pc          (deq_pc),
      .deq_inst        (deq_inst),
      .deq_pred_taken  (deq_pred_taken),
      .deq_pred_target (deq_pred_target),
      .count           (count),
      .almost_full     (almost_full)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Every entry's fields are derived from its PC so the head can be fully checked.
   task automatic enq_set(input logic [31:0] pc);
      enq_pc          = pc;
      enq_inst        = pc ^ 32'hA5A5_0000;
      enq_pred_taken  = pc[2];
      enq_pred_target = pc + 32'h100;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc);
      logic [31:0] exp_inst;
      logic [31:0] exp_tgt;
      logic [31:0] exp_tk;
      exp_inst = pc ^ 32'hA5A5_0000;
      exp_tgt  = pc + 32'h100;
      exp_tk   = {31'd0, pc[2]};
      chk({tag, "_vld"}, {31'd0, deq_valid}, 32'd1);
      chk({tag, "_pc"}, deq_pc, pc);
      chk({tag, "_inst"}, deq_inst, exp_inst);
      chk({tag, "_tk"}, {31'd0, deq_pred_taken}, exp_tk);
      chk({tag, "_tgt"}, deq_pred_target, exp_tgt);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc);
      enq_valid = 1'b1;
      enq_set(pc);
      tick();
      enq_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      enq_set(32'h0);
      #1;
      chk("rst_enq_rdy", {31'd0, enq_ready}, 32'd0);
      tick();
      tick();
      chk("rst_deq_vld", {31'd0, deq_valid}, 32'd0);
      chk("rst_count", {29'd0, count}, 32'd0);
      rst = 1'b1;
      #1;
      chk("post_rst_enq_rdy", {31'd0, enq_ready}, 32'd1);
      chk("post_rst_afull", {31'd0, almost_full}, 32'd0);
      chk("post_rst_deq_pc", deq_pc, 32'd0);

      // Fill to full with decode stalled.
      for (int i = 0; i < 4; i++) begin
         enq_valid = 1'b1;
         enq_set(32'(i * 4));
         #1;
         chk("fill_rdy", {31'd0, enq_ready}, 32'd1);
         tick();
         chk("fill_count", {29'd0, count}, 32'(i + 1));
         chk("fill_afull", {31'd0, almost_full}, (i + 1 >= 3) ? 32'd1 : 32'd0);
         chk("fill_deq_vld", {31'd0, deq_valid}, 32'd1);
      end
      enq_set(32'h99);
      #1;
      chk("full_enq_rdy", {31'd0, enq_ready}, 32'd0);
      chk_head("full_head", 32'h0);
      tick();
      chk("full_hold_count", {29'd0, count}, 32'd4);
      chk_head("stall_stable", 32'h0);
      deq_ready = 1'b1;
      #1;
      chk("full_deq_enq_rdy", {31'd0, enq_ready}, 32'd0);
      tick();
      enq_valid = 1'b0;
      #1;
      chk("after_deq_count", {29'd0, count}, 32'd3);
      chk("after_deq_enq_rdy", {31'd0, enq_ready}, 32'd1);
      for (int k = 1; k < 4; k++) begin
         chk_head("drain", 32'(k * 4));
         tick();
      end
      chk("drained_vld", {31'd0, deq_valid}, 32'd0);
      chk("drained_count", {29'd0, count}, 32'd0);
      deq_ready = 1'b0;

      // Two-deep occupancy with simultaneous enq/deq across pointer wrap.
      push(32'h200);
      push(32'h204);
      chk("simul_pre_count", {29'd0, count}, 32'd2);
      deq_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         enq_valid = 1'b1;
         enq_set(32'h208 + 32'(4 * k));
         #1;
         chk_head("simul", 32'h200 + 32'(4 * k));
         tick();
         chk("simul_count", {29'd0, count}, 32'd2);
      end
      enq_valid = 1'b0;
      #1;
      chk_head("wrap_tail0", 32'h220);
      tick();
      chk_head("wrap_tail1", 32'h224);
      tick();
      chk("wrap_count", {29'd0, count}, 32'd0);
      deq_ready = 1'b0;

      // Flush with both handshakes requested.
      push(32'h300);
      push(32'h304);
      push(32'h308);
      chk("flush_pre_count", {29'd0, count}, 32'd3);
      flush     = 1'b1;
      enq_valid = 1'b1;
      enq_set(32'h30C);
      deq_ready = 1'b1;
      #1;
      chk("flush_enq_rdy", {31'd0, enq_ready}, 32'd0);
      chk("flush_deq_vld", {31'd0, deq_valid}, 32'd0);
      tick();
      flush     = 1'b0;
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      #1;
      chk("post_flush_count", {29'd0, count}, 32'd0);
      chk("post_flush_deq_vld", {31'd0, deq_valid}, 32'd0);
      chk("post_flush_enq_rdy", {31'd0, enq_ready}, 32'd1);
      push(32'h310);
      chk("post_flush_refill", {29'd0, count}, 32'd1);
      chk_head("post_flush_head", 32'h310);

      // Reset mid-operation.
      push(32'h400);
      push(32'h404);
      chk("rst_mid_pre_count", {29'd0, count}, 32'd3);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_count", {29'd0, count}, 32'd0);
      chk("rst_mid_deq_vld", {31'd0, deq_valid}, 32'd0);
      chk("rst_mid_deq_pc", deq_pc, 32'd0);

      // Latency on an empty queue.
      enq_valid = 1'b1;
      enq_set(32'h40);
      deq_ready = 1'b1;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk_head("byp_same_cycle", 32'h40);
      tick();
      enq_valid = 1'b0;
      #1;
      chk("byp_count", {29'd0, count}, 32'd0);
      chk("byp_after_vld", {31'd0, deq_valid}, 32'd0);
`else
      chk("lat_same_cycle_vld", {31'd0, deq_valid}, 32'd0);
      tick();
      enq_valid = 1'b0;
      #1;
      chk_head("lat_next_cycle", 32'h40);
      chk("lat_count", {29'd0, count}, 32'd1);
      tick();
      chk("lat_drained_count", {29'd0, count}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
